// File: rtl/pair_inject_arbiter.sv
// Round-robin arbiter that forwards whole key/count pairs from NUM_NODES mapper nodes into one router FIFO.
// Optional build macro ARB_STATS_EN adds a saturating completed-pair counter output (pair_count).
module pair_inject_arbiter #(
    parameter int NUM_NODES      = 4,
    parameter int BEATS_PER_PAIR = 4,
    parameter int DATA_W         = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_NODES-1:0]          req_valid,
    input  logic [NUM_NODES*DATA_W-1:0]   req_data,
    output logic [NUM_NODES-1:0]          req_ready,
    input  logic                          fifo_in_ready,
    output logic [DATA_W-1:0]             data_out,
    output logic                          data_out_ready,
    output logic [$clog2(NUM_NODES)-1:0]  grant_id,
    output logic                          busy
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]                   pair_count
`endif
);

    localparam int ID_W  = $clog2(NUM_NODES);
    localparam int CNT_W = (BEATS_PER_PAIR > 1) ? $clog2(BEATS_PER_PAIR) : 1;

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t              state_r, state_n;
    logic [ID_W-1:0]     grant_id_r, rr_ptr_r, pick_id_s, cand_s;
    logic                pick_valid_s;
    logic [CNT_W-1:0]    beat_cnt_r;
    logic [DATA_W-1:0]   data_out_r, grant_data_s;
    logic                data_out_ready_r, beat_s, last_beat_s;

    // Round-robin search starting just after the last granted node.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_id_s    = rr_ptr_r;
        cand_s       = rr_ptr_r;
        for (int k = 1; k <= NUM_NODES; k++) begin
            cand_s = ID_W'((int'(rr_ptr_r) + k) % NUM_NODES);
            if (!pick_valid_s && req_valid[cand_s]) begin
                pick_valid_s = 1'b1;
                pick_id_s    = cand_s;
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

    // Select the granted node's beat and decide whether a beat moves this cycle.
    always_comb begin
        grant_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_NODES; i++) begin
            if (ID_W'(i) == grant_id_r) begin
                grant_data_s = req_data[i*DATA_W +: DATA_W];
            end else begin
                grant_data_s = grant_data_s;
            end
        end
        beat_s      = (state_r == XFER) && req_valid[grant_id_r] && fifo_in_ready;
        last_beat_s = (beat_cnt_r == CNT_W'(BEATS_PER_PAIR - 1));
    end

    // Handshake back to the nodes: only the granted node sees ready.
    always_comb begin
        req_ready = {NUM_NODES{1'b0}};
        for (int i = 0; i < NUM_NODES; i++) begin
            if (beat_s && (ID_W'(i) == grant_id_r)) begin
                req_ready[i] = 1'b1;
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) state_n = XFER;
                else              state_n = IDLE;
            end
            XFER: begin
                if (beat_s && last_beat_s) state_n = IDLE;
                else                       state_n = XFER;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_n;
    end

    // Grant, pointer, beat counter and registered output beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_r       <= {DATA_W{1'b0}};
            data_out_ready_r <= 1'b0;
            grant_id_r       <= {ID_W{1'b0}};
            rr_ptr_r         <= ID_W'(NUM_NODES - 1);
            beat_cnt_r       <= {CNT_W{1'b0}};
        end else begin
            if (beat_s) begin
                data_out_r       <= grant_data_s;
                data_out_ready_r <= 1'b1;
            end else begin
                data_out_r       <= {DATA_W{1'b0}};
                data_out_ready_r <= 1'b0;
            end
            if (state_r == IDLE && pick_valid_s) begin
                grant_id_r <= pick_id_s;
                rr_ptr_r   <= pick_id_s;
                beat_cnt_r <= {CNT_W{1'b0}};
            end else if (beat_s) begin
                beat_cnt_r <= last_beat_s ? {CNT_W{1'b0}} : beat_cnt_r + 1'b1;
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] pair_count_r;

    // Completed-pair counter; saturates, abandoned pairs never reach the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_count_r <= 16'h0000;
        end else if (beat_s && last_beat_s && (pair_count_r != 16'hFFFF)) begin
            pair_count_r <= pair_count_r + 16'h0001;
        end else begin
            pair_count_r <= pair_count_r;
        end
    end

    assign pair_count = pair_count_r;
`endif

    assign data_out       = data_out_r;
    assign data_out_ready = data_out_ready_r;
    assign grant_id       = grant_id_r;
    assign busy           = (state_r == XFER);

endmodule

// File: tb/tb_pair_inject_arbiter.sv
// Self-checking bench for pair_inject_arbiter: directed scenarios plus randomized traffic
// compared against a pair-level behavioural model.
module tb_pair_inject_arbiter;

    localparam int N = 4;
    localparam int B = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_in_ready;
    logic [W-1:0]   data_out;
    logic           data_out_ready;
    logic [1:0]     grant_id;
    logic           busy;
`ifdef ARB_STATS_EN
    logic [15:0]    pair_count;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the port, how many beats of the pair are done.
    bit           m_busy;
    int           m_owner;
    int           m_last;
    int           m_done;
    int           m_pairs;
    logic [W-1:0] m_out;
    logic         m_out_v;

    always #5 clk = ~clk;

    pair_inject_arbiter #(.NUM_NODES(N), .BEATS_PER_PAIR(B), .DATA_W(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .fifo_in_ready  (fifo_in_ready),
        .data_out       (data_out),
        .data_out_ready (data_out_ready),
        .grant_id       (grant_id),
        .busy           (busy)
`ifdef ARB_STATS_EN
        ,
        .pair_count     (pair_count)
`endif
    );

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = $urandom;
        return r;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, return at the falling edge.
    task automatic step(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] d, input logic f);
        rst = r; req_valid = v; req_data = d; fifo_in_ready = f;
        @(posedge clk);
        if (r) begin
            m_busy = 0; m_owner = 0; m_last = N - 1; m_done = 0; m_pairs = 0;
            m_out = '0; m_out_v = 1'b0;
        end else if (!m_busy) begin
            m_out = '0; m_out_v = 1'b0;
            for (int k = 1; k <= N; k++) begin
                if (v[(m_last + k) % N]) begin
                    m_owner = (m_last + k) % N;
                    m_last  = m_owner;
                    m_busy  = 1;
                    m_done  = 0;
                    break;
                end
            end
        end else if (v[m_owner] && f) begin
            m_out = d[m_owner*W +: W]; m_out_v = 1'b1;
            m_done++;
            if (m_done == B) begin
                m_busy = 0;
                if (m_pairs < 65535) m_pairs++;
            end
        end else begin
            m_out = '0; m_out_v = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1'b1, 4'b1111, rand_data(), 1'b1);
        step(1'b1, 4'b1111, rand_data(), 1'b1);
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL reset_data_out: got %h want 0", data_out); end
        total++; if (data_out_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", data_out_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
`ifdef ARB_STATS_EN
        total++; if (pair_count !== 16'd0) begin bad++; $display("FAIL reset_pair_count: got %0d want 0", pair_count); end
`endif
    endtask

    task automatic test_single_node();
        logic [N*W-1:0] d;
        logic [W-1:0]   base, exp_d;
        logic           exp_v, exp_b;
        base = 32'hA000_0000;
        step(1'b1, 4'b0000, '0, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            d = rand_data();
            d[W-1:0] = base + W'(i - 2);
            step(1'b0, 4'b0001, d, 1'b1);
            exp_v = (i >= 2 && i <= 5) || (i == 7);
            exp_b = (i <= 4) || (i >= 6);
            exp_d = exp_v ? base + W'(i - 2) : 32'h0;
            total++; if (data_out_ready !== exp_v) begin bad++; $display("FAIL single_ready[%0d]: got %b want %b", i, data_out_ready, exp_v); end
            total++; if (data_out !== exp_d) begin bad++; $display("FAIL single_data[%0d]: got %h want %h", i, data_out, exp_d); end
            total++; if (busy !== exp_b) begin bad++; $display("FAIL single_busy[%0d]: got %b want %b", i, busy, exp_b); end
            total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL single_grant[%0d]: got %0d want 0", i, grant_id); end
        end
    endtask

    task automatic test_all_nodes();
        int   grants[$];
        int   exp_order[5];
        logic prev_busy;
        exp_order = '{0, 1, 2, 3, 0};
        step(1'b1, 4'b0000, '0, 1'b1);
        prev_busy = 1'b0;
        for (int c = 0; c < 25; c++) begin
            step(1'b0, 4'b1111, rand_data(), 1'b1);
            if (busy === 1'b1 && prev_busy === 1'b0) grants.push_back(int'(grant_id));
            prev_busy = busy;
            total++; if (data_out !== m_out || data_out_ready !== m_out_v) begin
                bad++; $display("FAIL all_beat[%0d]: got %h/%b want %h/%b", c, data_out, data_out_ready, m_out, m_out_v);
            end
        end
        total++; if (grants.size() != 5) begin bad++; $display("FAIL all_grant_count: got %0d want 5", grants.size()); end
        for (int g = 0; g < 5 && g < grants.size(); g++) begin
            total++; if (grants[g] != exp_order[g]) begin bad++; $display("FAIL all_grant_order[%0d]: got %0d want %0d", g, grants[g], exp_order[g]); end
        end
    endtask

    task automatic test_backpressure();
        logic [N*W-1:0] d;
        logic [W-1:0]   got[$];
        logic           fpat[7];
        int             acc;
        fpat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        step(1'b1, 4'b0000, '0, 1'b1);
        d = rand_data(); d[2*W +: W] = 32'hC200_0000;
        step(1'b0, 4'b0100, d, 1'b1);
        acc = 0;
        for (int i = 0; i < 7; i++) begin
            d = rand_data(); d[2*W +: W] = 32'hC200_0000 + W'(acc);
            step(1'b0, 4'b0100, d, fpat[i]);
            if (fpat[i]) acc++;
            if (data_out_ready === 1'b1) got.push_back(data_out);
            if (!fpat[i]) begin
                total++; if (data_out_ready !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd2) begin
                    bad++; $display("FAIL bp_stall[%0d]: got rdy=%b busy=%b grant=%0d want 0/1/2", i, data_out_ready, busy, grant_id);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 4'b0000, rand_data(), 1'b1);
            if (data_out_ready === 1'b1) got.push_back(data_out);
        end
        total++; if (got.size() != 4) begin bad++; $display("FAIL bp_beat_count: got %0d want 4", got.size()); end
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            total++; if (got[k] !== 32'hC200_0000 + W'(k)) begin bad++; $display("FAIL bp_beat[%0d]: got %h want %h", k, got[k], 32'hC200_0000 + W'(k)); end
        end
    endtask

    task automatic test_drop_valid();
        logic [N*W-1:0] d;
        logic [3:0]     vpat[8];
        int             acc;
        vpat = '{4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b1000, 4'b1010, 4'b1000};
        step(1'b1, 4'b0000, '0, 1'b1);
        d = rand_data(); d[W +: W] = 32'hB100_0000;
        step(1'b0, 4'b1010, d, 1'b1);
        total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL drop_first_grant: got %0d want 1", grant_id); end
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            d = rand_data(); d[W +: W] = 32'hB100_0000 + W'(acc);
            step(1'b0, vpat[i], d, 1'b1);
            if (vpat[i][1]) acc++;
            if (i >= 3 && i <= 5) begin
                total++; if (grant_id !== 2'd1 || busy !== 1'b1 || data_out_ready !== 1'b0 || req_ready !== 4'b0000) begin
                    bad++; $display("FAIL drop_hold[%0d]: got grant=%0d busy=%b rdy=%b req_ready=%b want 1/1/0/0000", i, grant_id, busy, data_out_ready, req_ready);
                end
            end
        end
        total++; if (grant_id !== 2'd3 || busy !== 1'b1) begin bad++; $display("FAIL drop_next_grant: got %0d/%b want 3/1", grant_id, busy); end
        step(1'b0, 4'b1000, rand_data(), 1'b1);
        total++; if (data_out !== m_out || data_out_ready !== 1'b1) begin bad++; $display("FAIL drop_node3_beat: got %h/%b want %h/1", data_out, data_out_ready, m_out); end
    endtask

    task automatic test_mid_reset();
        logic [N*W-1:0] d;
        step(1'b1, 4'b0000, '0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            d = rand_data(); d[W-1:0] = 32'hF000_0000 + W'(i);
            step(1'b0, 4'b0001, d, 1'b1);
        end
`ifdef ARB_STATS_EN
        total++; if (pair_count !== 16'd1) begin bad++; $display("FAIL mrst_count_before: got %0d want 1", pair_count); end
`endif
        step(1'b1, 4'b0001, rand_data(), 1'b1);
        total++; if (data_out !== 32'h0 || data_out_ready !== 1'b0) begin bad++; $display("FAIL mrst_out: got %h/%b want 0/0", data_out, data_out_ready); end
        total++; if (busy !== 1'b0 || grant_id !== 2'd0) begin bad++; $display("FAIL mrst_state: got busy=%b grant=%0d want 0/0", busy, grant_id); end
`ifdef ARB_STATS_EN
        total++; if (pair_count !== 16'd0) begin bad++; $display("FAIL mrst_count: got %0d want 0", pair_count); end
`endif
        d = rand_data(); d[W-1:0] = 32'hE000_0000;
        step(1'b0, 4'b0011, d, 1'b1);
        total++; if (grant_id !== 2'd0 || busy !== 1'b1 || data_out_ready !== 1'b0) begin
            bad++; $display("FAIL mrst_regrant: got grant=%0d busy=%b rdy=%b want 0/1/0", grant_id, busy, data_out_ready);
        end
        step(1'b0, 4'b0011, d, 1'b1);
        total++; if (data_out !== 32'hE000_0000 || data_out_ready !== 1'b1) begin bad++; $display("FAIL mrst_first_beat: got %h/%b want e0000000/1", data_out, data_out_ready); end
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        step(1'b1, 4'b0000, '0, 1'b1);
        for (int c = 0; c < 25; c++) step(1'b0, 4'b1111, rand_data(), 1'b1);
        total++; if (pair_count !== 16'd5) begin bad++; $display("FAIL stats_five: got %0d want 5", pair_count); end
        for (int c = 0; c < 3; c++) step(1'b0, 4'b0000, rand_data(), 1'b1);
        total++; if (pair_count !== 16'd5) begin bad++; $display("FAIL stats_hold: got %0d want 5", pair_count); end
    endtask
`endif

    task automatic test_random();
        logic [N-1:0]   v;
        logic [N*W-1:0] d;
        logic           f, r;
        logic [N-1:0]   exp_rr;
        step(1'b1, 4'b0000, '0, 1'b1);
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 4) != 0);
            r = ($urandom_range(0, 149) == 0);
            d = rand_data();
            rst = r; req_valid = v; req_data = d; fifo_in_ready = f;
            #1;
            exp_rr = '0;
            if (m_busy && v[m_owner] && f) exp_rr[m_owner] = 1'b1;
            total++; if (req_ready !== exp_rr) begin bad++; $display("FAIL rand_req_ready[%0d]: got %b want %b", c, req_ready, exp_rr); end
            step(r, v, d, f);
            total++; if (data_out !== m_out || data_out_ready !== m_out_v) begin
                bad++; $display("FAIL rand_beat[%0d]: got %h/%b want %h/%b", c, data_out, data_out_ready, m_out, m_out_v);
            end
            total++; if (busy !== m_busy || grant_id !== m_owner[1:0]) begin
                bad++; $display("FAIL rand_state[%0d]: got busy=%b grant=%0d want %b/%0d", c, busy, grant_id, m_busy, m_owner);
            end
`ifdef ARB_STATS_EN
            total++; if (pair_count !== m_pairs[15:0]) begin bad++; $display("FAIL rand_pair_count[%0d]: got %0d want %0d", c, pair_count, m_pairs); end
`endif
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; fifo_in_ready = 1'b0;
        m_busy = 0; m_owner = 0; m_last = N - 1; m_done = 0; m_pairs = 0; m_out = '0; m_out_v = 1'b0;
        test_reset();
        test_single_node();
        test_all_nodes();
        test_backpressure();
        test_drop_valid();
        test_mid_reset();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
